jacobi_pivot_search: RTL and testbench

JACOBI_PIVOT_SEARCH -- requirements
Module: jacobi_pivot_search

---
 rtl/jacobi_pivot_search.sv | 159 +++++++++++++++
 tb/tb_jacobi_pivot_search.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_pivot_search.sv
// jacobi_pivot_search: scans the strict upper triangle of a 32x32 single-precision
// matrix, one element per cycle, and reports the largest-magnitude element, its
// position, whether it falls below the convergence threshold, and whether any
// scanned element was NaN.
module jacobi_pivot_search #(
    parameter logic [31:0] EPS = 32'h3727C5AC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          row_valid,
    input  logic [4:0]    row_index,
    input  logic [1023:0] row_data,
    output logic          row_ready,
    output logic          busy,
    output logic          done,
    output logic [4:0]    pivot_p,
    output logic [4:0]    pivot_q,
    output logic [31:0]   pivot_val,
    output logic          converged,
    output logic          nan_seen
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ROW = 2'd1;
    localparam logic [1:0] SCAN     = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]    state;
    logic [5:0]    row_cnt;
    logic [4:0]    col_j;
    logic [1023:0] row_buf;
    logic [4:0]    row_idx;

    logic [30:0]   max_mag;
    logic [4:0]    max_p;
    logic [4:0]    max_q;
    logic [31:0]   max_val;
    logic          nan_flag;

    logic [31:0]   elem;
    logic          upper;
    logic          take;
    logic          elem_nan;
    logic [30:0]   nxt_mag;
    logic [4:0]    nxt_p;
    logic [4:0]    nxt_q;
    logic [31:0]   nxt_val;
    logic          nxt_nan;

    // Exponent all ones with a nonzero mantissa; infinities are not NaN.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Sign-stripped bits order IEEE singles by magnitude as plain unsigned values,
    // which also makes -0 and +0 compare equal.
    function automatic logic [30:0] magnitude(input logic [31:0] x);
        return x[30:0];
    endfunction

    assign row_ready = (state == WAIT_ROW);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Evaluate the current column and form the running maximum after this cycle.
    always_comb begin
        elem     = row_buf[32*col_j +: 32];
        upper    = (col_j > row_idx);
        elem_nan = upper && is_nan(elem);
        take     = upper && !is_nan(elem) && (magnitude(elem) > max_mag);
        nxt_mag  = max_mag;
        nxt_p    = max_p;
        nxt_q    = max_q;
        nxt_val  = max_val;
        nxt_nan  = nan_flag | elem_nan;
        if (take) begin
            nxt_mag = magnitude(elem);
            nxt_p   = row_idx;
            nxt_q   = col_j;
            nxt_val = elem;
        end
    end

    // Row buffer holds only data, so it is loaded on accept without reset.
    always_ff @(posedge clk) begin
        if (state == WAIT_ROW && row_valid) begin
            row_buf <= row_data;
            row_idx <= row_index;
        end
    end

    // Control FSM, running maximum and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row_cnt   <= 6'd0;
            col_j     <= 5'd0;
            max_mag   <= 31'd0;
            max_p     <= 5'd0;
            max_q     <= 5'd0;
            max_val   <= 32'd0;
            nan_flag  <= 1'b0;
            pivot_p   <= 5'd0;
            pivot_q   <= 5'd0;
            pivot_val <= 32'd0;
            converged <= 1'b0;
            nan_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_ROW;
                        row_cnt  <= 6'd0;
                        col_j    <= 5'd0;
                        max_mag  <= 31'd0;
                        max_p    <= 5'd0;
                        max_q    <= 5'd1;
                        max_val  <= 32'd0;
                        nan_flag <= 1'b0;
                    end
                end
                WAIT_ROW: begin
                    if (row_valid) begin
                        row_cnt <= row_cnt + 6'd1;
                        col_j   <= 5'd0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    max_mag  <= nxt_mag;
                    max_p    <= nxt_p;
                    max_q    <= nxt_q;
                    max_val  <= nxt_val;
                    nan_flag <= nxt_nan;
                    col_j    <= col_j + 5'd1;
                    if (col_j == 5'd31) begin
                        if (row_cnt == 6'd32) begin
                            // Results include the final element, so they load from
                            // the next-state values and are valid alongside done.
                            state     <= DONE;
                            pivot_p   <= nxt_p;
                            pivot_q   <= nxt_q;
                            pivot_val <= nxt_val;
                            converged <= (nxt_mag < EPS[30:0]);
                            nan_seen  <= nxt_nan;
                        end else begin
                            state <= WAIT_ROW;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jacobi_pivot_search.sv
// Directed bench for jacobi_pivot_search: identity, distinct max, ties,
// lower-triangle only, NaN with exact latency, mid-search reset, result hold.
module tb_jacobi_pivot_search;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          row_valid;
    logic [4:0]    row_index;
    logic [1023:0] row_data;
    logic          row_ready;
    logic          busy;
    logic          done;
    logic [4:0]    pivot_p;
    logic [4:0]    pivot_q;
    logic [31:0]   pivot_val;
    logic          converged;
    logic          nan_seen;

    logic [31:0] mat [32][32];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    jacobi_pivot_search dut (
        .clk(clk), .reset(reset), .start(start), .row_valid(row_valid),
        .row_index(row_index), .row_data(row_data), .row_ready(row_ready),
        .busy(busy), .done(done), .pivot_p(pivot_p), .pivot_q(pivot_q),
        .pivot_val(pivot_val), .converged(converged), .nan_seen(nan_seen)
    );

    task automatic clear_mat(input logic [31:0] diag, input logic [31:0] up);
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                mat[i][j] = (i == j) ? diag : ((j > i) ? up : 32'd0);
    endtask

    task automatic present_row(input int r);
        row_index = r[4:0];
        for (int j = 0; j < 32; j++) row_data[32*j +: 32] = mat[r][j];
    endtask

    // Runs a full search with row_valid held; edges counts rising edges after the start edge.
    task automatic run_search(input bit inject_start, output int edges, output bit ok);
        int r;
        r = 0;
        edges = 0;
        ok = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        row_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (inject_start) start = (n == 100);
            if (row_ready && r < 32) begin
                present_row(r);
                r++;
            end
            @(negedge clk);
            edges++;
        end
        row_valid = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (!ok) $display("FAIL search_timeout got no done after %0d edges, required done", edges);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        row_valid = 1'b0;
        row_index = 5'd0;
        row_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (row_ready !== 1'b0) $display("FAIL rst_row_ready got %b required 0", row_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %b required 0", done); else pass_cnt++;
        total_cnt++; if (pivot_p !== 5'd0 || pivot_q !== 5'd0) $display("FAIL rst_pq got %0d,%0d required 0,0", pivot_p, pivot_q); else pass_cnt++;
        total_cnt++; if (pivot_val !== 32'd0) $display("FAIL rst_val got %h required 00000000", pivot_val); else pass_cnt++;
        total_cnt++; if (converged !== 1'b0 || nan_seen !== 1'b0) $display("FAIL rst_flags got %b%b required 00", converged, nan_seen); else pass_cnt++;
    endtask

    // Generic result check used inline per scenario via explicit comparisons.
    task automatic test_identity();
        int e;
        bit ok;
        clear_mat(32'h3F800000, 32'h0);
        run_search(1'b1, e, ok);
        total_cnt++; if (e !== 1056) $display("FAIL ident_latency got %0d required 1056", e); else pass_cnt++;
        total_cnt++; if (pivot_p !== 5'd0 || pivot_q !== 5'd1) $display("FAIL ident_pq got %0d,%0d required 0,1", pivot_p, pivot_q); else pass_cnt++;
        total_cnt++; if (pivot_val !== 32'h0) $display("FAIL ident_val got %h required 00000000", pivot_val); else pass_cnt++;
        total_cnt++; if (converged !== 1'b1 || nan_seen !== 1'b0) $display("FAIL ident_flags got conv=%b nan=%b required 1,0", converged, nan_seen); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ident_pulse got done=%b busy=%b required 0,0", done, busy); else pass_cnt++;
    endtask

    task automatic test_distinct_max();
        int e;
        bit ok;
        clear_mat(32'h3F800000, 32'h3F000000);
        mat[3][17] = 32'hC0400000;
        run_search(1'b0, e, ok);
        total_cnt++; if (pivot_p !== 5'd3 || pivot_q !== 5'd17) $display("FAIL max_pq got %0d,%0d required 3,17", pivot_p, pivot_q); else pass_cnt++;
        total_cnt++; if (pivot_val !== 32'hC0400000) $display("FAIL max_val got %h required C0400000", pivot_val); else pass_cnt++;
        total_cnt++; if (converged !== 1'b0 || nan_seen !== 1'b0) $display("FAIL max_flags got conv=%b nan=%b required 0,0", converged, nan_seen); else pass_cnt++;
    endtask

    task automatic test_ties();
        int e;
        bit ok;
        clear_mat(32'h0, 32'h0);
        mat[2][5] = 32'h40000000;
        mat[4][9] = 32'hC0000000;
        run_search(1'b0, e, ok);
        total_cnt++; if (pivot_p !== 5'd2 || pivot_q !== 5'd5) $display("FAIL tie_pq got %0d,%0d required 2,5", pivot_p, pivot_q); else pass_cnt++;
        total_cnt++; if (pivot_val !== 32'h40000000) $display("FAIL tie_val got %h required 40000000", pivot_val); else pass_cnt++;
    endtask

    task automatic test_lower_only();
        int e;
        bit ok;
        clear_mat(32'h3F800000, 32'h0);
        mat[10][4] = 32'h41200000;
        run_search(1'b0, e, ok);
        total_cnt++; if (pivot_p !== 5'd0 || pivot_q !== 5'd1 || pivot_val !== 32'h0) $display("FAIL lower_res got %0d,%0d,%h required 0,1,00000000", pivot_p, pivot_q, pivot_val); else pass_cnt++;
        total_cnt++; if (converged !== 1'b1) $display("FAIL lower_conv got %b required 1", converged); else pass_cnt++;
    endtask

    task automatic test_nan();
        int e;
        bit ok;
        clear_mat(32'h0, 32'h0);
        mat[0][31] = 32'h7FC00000;
        mat[1][2]  = 32'h3F800000;
        run_search(1'b0, e, ok);
        total_cnt++; if (e !== 1056) $display("FAIL nan_latency got %0d required 1056", e); else pass_cnt++;
        total_cnt++; if (nan_seen !== 1'b1) $display("FAIL nan_flag got %b required 1", nan_seen); else pass_cnt++;
        total_cnt++; if (pivot_p !== 5'd1 || pivot_q !== 5'd2) $display("FAIL nan_pq got %0d,%0d required 1,2", pivot_p, pivot_q); else pass_cnt++;
        total_cnt++; if (pivot_val !== 32'h3F800000) $display("FAIL nan_val got %h required 3F800000", pivot_val); else pass_cnt++;
    endtask

    // Results of the NaN search must hold through part of a following search.
    task automatic test_result_hold();
        clear_mat(32'h0, 32'h0);
        mat[0][1] = 32'h7F800000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        row_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (row_ready) present_row(n / 33);
            @(negedge clk);
        end
        total_cnt++; if (pivot_p !== 5'd1 || pivot_q !== 5'd2 || pivot_val !== 32'h3F800000 || nan_seen !== 1'b1) $display("FAIL hold_res got %0d,%0d,%h,%b required 1,2,3F800000,1", pivot_p, pivot_q, pivot_val, nan_seen); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL hold_busy got %b required 1", busy); else pass_cnt++;
        row_valid = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int e;
        bit ok;
        bit saw_done;
        int r;
        clear_mat(32'h3F800000, 32'h3F000000);
        mat[3][17] = 32'hC0400000;
        r = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        row_valid = 1'b1;
        for (int n = 0; n < 400 && r < 8; n++) begin
            if (row_ready) begin
                present_row(r);
                r++;
            end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        row_valid = 1'b0;
        total_cnt++; if (busy !== 1'b0 || row_ready !== 1'b0) $display("FAIL midrst_ctrl got busy=%b ready=%b required 0,0", busy, row_ready); else pass_cnt++;
        total_cnt++; if (pivot_p !== 5'd0 || pivot_q !== 5'd0 || pivot_val !== 32'd0 || converged !== 1'b0 || nan_seen !== 1'b0) $display("FAIL midrst_out got %0d,%0d,%h,%b%b required all 0", pivot_p, pivot_q, pivot_val, converged, nan_seen); else pass_cnt++;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (saw_done !== 1'b0) $display("FAIL midrst_nodone got %b required 0", saw_done); else pass_cnt++;
        run_search(1'b0, e, ok);
        total_cnt++; if (pivot_p !== 5'd3 || pivot_q !== 5'd17 || pivot_val !== 32'hC0400000 || converged !== 1'b0) $display("FAIL midrst_rerun got %0d,%0d,%h,%b required 3,17,C0400000,0", pivot_p, pivot_q, pivot_val, converged); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_distinct_max();
        test_ties();
        test_lower_only();
        test_nan();
        test_result_hold();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
